// File: rtl/clock_set_ctrl_if.sv
// Front-panel bus of the clock set controller: raw buttons in, counter/display controls out.
// The controller uses the slave view; the panel/counter side uses the master view.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_en;
  logic       hr_set_H;
  logic       hr_set_L;
  logic       min_set_H;
  logic       min_set_L;
  logic       sec_clr;
  logic [1:0] digit_sel;
  logic       blink_on;

  modport master (
    output btn_mode, btn_inc,
    input  run_en, hr_set_H, hr_set_L, min_set_H, min_set_L, sec_clr, digit_sel, blink_on
  );

  modport slave (
    input  btn_mode, btn_inc,
    output run_en, hr_set_H, hr_set_L, min_set_H, min_set_L, sec_clr, digit_sel, blink_on
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the BCD time-of-day counters: debounces MODE/INC, walks the
// digit-edit state machine, and issues increment pulses, blink and inactivity timeout.
module clock_set_ctrl #(
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int BLINK_HALF   = 250,
  parameter int TIMEOUT      = 5000
) (
  input logic             clk,
  input logic             clr,
  clock_set_ctrl_if.slave bus
);

  localparam int DBW   = $clog2(DB_CYCLES + 1);
  localparam int RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW   = $clog2(RPMAX + 1);
  localparam int BLW   = $clog2(BLINK_HALF + 1);
  localparam int TOW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {RUN, SET_HH, SET_HL, SET_MH, SET_ML} state_t;

  state_t           state;
  state_t           next_state;
  state_t           target;

  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [1:0]       db_q;
  logic [DBW-1:0]   db_cnt [2];

  logic             mode_press;
  logic             inc_press;
  logic             inc_held;
  logic             in_set;
  logic             rep_due;
  logic             fire;
  logic             time_up;
  logic             change;

  logic             rep_armed;
  logic             rep_first;
  logic [RPW-1:0]   rep_cnt;
  logic [BLW-1:0]   blink_cnt;
  logic [TOW-1:0]   to_cnt;

  function automatic logic [1:0] digit_of(input state_t s);
    case (s)
      SET_HL:  return 2'd1;
      SET_MH:  return 2'd2;
      SET_ML:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign raw = {bus.btn_inc, bus.btn_mode};

  // Bit 0 is MODE, bit 1 is INC; a level only moves after DB_CYCLES unbroken disagreeing samples.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign mode_press = db[0] & ~db_q[0];
  assign inc_press  = db[1] & ~db_q[1];
  assign inc_held   = db[1];

  always_comb begin
    next_state = RUN;
    case (state)
      RUN:     next_state = SET_HH;
      SET_HH:  next_state = SET_HL;
      SET_HL:  next_state = SET_MH;
      SET_MH:  next_state = SET_ML;
      default: next_state = RUN;
    endcase
  end

  // MODE beats INC; a set pulse (press or repeat) counts as activity and so beats the timeout.
  assign in_set  = (state != RUN);
  assign rep_due = rep_armed && inc_held &&
                   (rep_cnt == (rep_first ? RPW'(REPEAT_DELAY - 1) : RPW'(REPEAT_RATE - 1)));
  assign fire    = in_set && !mode_press && (inc_press || rep_due);
  assign time_up = in_set && !mode_press && !fire && (to_cnt == TOW'(TIMEOUT - 1));
  assign change  = mode_press || time_up;
  assign target  = time_up ? RUN : next_state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= RUN;
      bus.run_en    <= 1'b1;
      bus.hr_set_H  <= 1'b0;
      bus.hr_set_L  <= 1'b0;
      bus.min_set_H <= 1'b0;
      bus.min_set_L <= 1'b0;
      bus.sec_clr   <= 1'b0;
      bus.digit_sel <= 2'd0;
      bus.blink_on  <= 1'b1;
      rep_armed     <= 1'b0;
      rep_first     <= 1'b0;
      rep_cnt       <= '0;
      blink_cnt     <= '0;
      to_cnt        <= '0;
    end else begin
      bus.hr_set_H  <= 1'b0;
      bus.hr_set_L  <= 1'b0;
      bus.min_set_H <= 1'b0;
      bus.min_set_L <= 1'b0;
      bus.sec_clr   <= 1'b0;
      if (change) begin
        state         <= target;
        bus.run_en    <= (target == RUN);
        bus.sec_clr   <= (target == RUN);
        bus.digit_sel <= digit_of(target);
        bus.blink_on  <= 1'b1;
        blink_cnt     <= '0;
        to_cnt        <= '0;
        rep_armed     <= 1'b0;
        rep_cnt       <= '0;
      end else if (fire) begin
        bus.hr_set_H  <= (state == SET_HH);
        bus.hr_set_L  <= (state == SET_HL);
        bus.min_set_H <= (state == SET_MH);
        bus.min_set_L <= (state == SET_ML);
        rep_armed     <= 1'b1;
        rep_first     <= inc_press;
        rep_cnt       <= '0;
        to_cnt        <= '0;
        bus.blink_on  <= 1'b1;
        blink_cnt     <= '0;
      end else if (in_set) begin
        to_cnt <= to_cnt + TOW'(1);
        if (blink_cnt == BLW'(BLINK_HALF - 1)) begin
          bus.blink_on <= ~bus.blink_on;
          blink_cnt    <= '0;
        end else begin
          blink_cnt <= blink_cnt + BLW'(1);
        end
        // Repeat only survives while INC stays held since the press that armed it.
        if (rep_armed && inc_held) begin
          rep_cnt <= rep_cnt + RPW'(1);
        end else begin
          rep_armed <= 1'b0;
          rep_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed front-panel scenarios plus random button activity,
// compared every cycle against an event-level model of the controller's rules.
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int BH = 8;
  localparam int TO = 100;
  localparam logic [8:0] RESET_VEC = 9'b1_0000_0_00_1;

  logic clk = 1'b0;
  logic clr;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: st 0=RUN, 1..4 = editing digit st-1; phase/idle/since are cycle ages.
  int m_st, m_pulse, m_phase, m_idle, m_since;
  bit m_sec, m_rep, m_first;
  bit m_dbm, m_dbi, m_dbm_q, m_dbi_q;
  bit hist_m[$];
  bit hist_i[$];

  int cyc, cnt_hH, cnt_hL, cnt_mH, cnt_mL, sec_cnt, blink_toggles, sd_changes, last_sd_change;
  int pulse_cycs[$];
  logic       prev_blink;
  logic [2:0] prev_sd;

  function automatic void model_reset();
    m_st = 0; m_pulse = -1; m_phase = 0; m_idle = 0; m_since = 0;
    m_sec = 0; m_rep = 0; m_first = 0;
    m_dbm = 0; m_dbi = 0; m_dbm_q = 0; m_dbi_q = 0;
    hist_m.delete(); hist_i.delete();
    hist_m.push_back(1'b0); hist_m.push_back(1'b0);
    hist_i.push_back(1'b0); hist_i.push_back(1'b0);
  endfunction

  // A debounced level flips once the DB synchronised samples before the newest two all disagree with it.
  function automatic bit deb_next(input bit q[$], input bit cur);
    if (q.size() < DB + 2) return cur;
    for (int j = 0; j < DB; j++) if (q[q.size() - 3 - j] == cur) return cur;
    return !cur;
  endfunction

  function automatic void model_enter(input int s);
    m_st = s; m_phase = 0; m_idle = 0; m_rep = 0; m_since = 0;
    if (s == 0) m_sec = 1;
  endfunction

  function automatic void model_step(input bit rm, input bit ri);
    bit pm, pi, held;
    pm = m_dbm && !m_dbm_q;
    pi = m_dbi && !m_dbi_q;
    held = m_dbi;
    hist_m.push_back(rm);
    hist_i.push_back(ri);
    if (hist_m.size() > DB + 2) void'(hist_m.pop_front());
    if (hist_i.size() > DB + 2) void'(hist_i.pop_front());
    m_dbm_q = m_dbm; m_dbi_q = m_dbi;
    m_dbm = deb_next(hist_m, m_dbm);
    m_dbi = deb_next(hist_i, m_dbi);
    m_pulse = -1; m_sec = 0;
    if (m_st == 0) begin
      if (pm) model_enter(1);
    end else if (pm) begin
      model_enter((m_st + 1) % 5);
    end else if (pi || (m_rep && held && (m_since + 1 == (m_first ? RD : RR)))) begin
      m_pulse = m_st - 1; m_rep = 1; m_first = pi; m_since = 0; m_idle = 0; m_phase = 0;
    end else if (m_idle + 1 == TO) begin
      model_enter(0);
    end else begin
      m_idle++; m_phase++;
      if (m_rep && held) m_since++;
      else m_rep = 0;
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] p;
    logic [1:0] d;
    logic       b;
    p = (m_pulse >= 0) ? (4'b1000 >> m_pulse) : 4'b0000;
    d = (m_st == 0) ? 2'd0 : 2'(m_st - 1);
    b = (m_st == 0) ? 1'b1 : (((m_phase / BH) % 2) == 0);
    return {(m_st == 0), p, m_sec, d, b};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.run_en, bus.hr_set_H, bus.hr_set_L, bus.min_set_H, bus.min_set_L,
            bus.sec_clr, bus.digit_sel, bus.blink_on};
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearMonitor();
    cnt_hH = 0; cnt_hL = 0; cnt_mH = 0; cnt_mL = 0;
    sec_cnt = 0; blink_toggles = 0; sd_changes = 0;
    pulse_cycs.delete();
  endtask

  // Drive from a falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic applyStimulus(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      bus.btn_mode = m;
      bus.btn_inc  = i;
      @(posedge clk);
      if (!clr) model_step(m, i);
      @(negedge clk);
      cyc++;
      checkOutput("cycle", obs_vec(), exp_vec());
      if (bus.hr_set_H) cnt_hH++;
      if (bus.hr_set_L) begin cnt_hL++; pulse_cycs.push_back(cyc); end
      if (bus.min_set_H) cnt_mH++;
      if (bus.min_set_L) cnt_mL++;
      if (bus.sec_clr) sec_cnt++;
      if (bus.blink_on !== prev_blink) blink_toggles++;
      prev_blink = bus.blink_on;
      if ({bus.run_en, bus.digit_sel} !== prev_sd) begin
        sd_changes++;
        last_sd_change = cyc;
      end
      prev_sd = {bus.run_en, bus.digit_sel};
    end
  endtask

  task automatic pressMode();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
  endtask

  initial begin
    int lat, entry, elapsed;
    int exp_off[7];
    exp_off = '{0, 20, 25, 30, 35, 40, 45};
    cyc = 0; last_sd_change = 0;
    prev_blink = 1'b1; prev_sd = 3'b100;
    clearMonitor();
    clr = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset", obs_vec(), RESET_VEC);
    clr = 1'b0;

    $display("[TB] debounce of a bouncing MODE button");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 2);
    end
    checkCount("glitch_no_advance", sd_changes, 0);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      if (lat < 0 && bus.run_en === 1'b0) lat = k;
    end
    checkCount("db_latency", lat, 7);
    checkCount("single_advance", sd_changes, 1);
    applyStimulus(1'b0, 1'b0, 8);
    checkCount("digit_hh", int'(bus.digit_sel), 0);

    $display("[TB] full MODE cycle");
    clearMonitor();
    for (int d = 1; d <= 3; d++) begin
      pressMode();
      checkCount("digit_walk", int'(bus.digit_sel), d);
    end
    pressMode();
    checkCount("cycle_sec_clr", sec_cnt, 1);
    checkCount("cycle_run_en", int'(bus.run_en), 1);

    $display("[TB] INC press and auto-repeat in SET_HL");
    pressMode();
    pressMode();
    clearMonitor();
    applyStimulus(1'b0, 1'b1, 50);
    applyStimulus(1'b0, 1'b0, 10);
    checkCount("repeat_count", cnt_hL, 7);
    for (int k = 0; k < 7; k++)
      checkCount("repeat_offset",
                 (k < pulse_cycs.size()) ? pulse_cycs[k] - pulse_cycs[0] : -1, exp_off[k]);
    checkCount("repeat_other_pulses", cnt_hH + cnt_mH + cnt_mL, 0);

    $display("[TB] simultaneous MODE and INC in SET_MH");
    pressMode();
    clearMonitor();
    applyStimulus(1'b1, 1'b1, 30);
    checkCount("simul_digit", int'(bus.digit_sel), 3);
    applyStimulus(1'b0, 1'b1, 30);
    applyStimulus(1'b0, 1'b0, 10);
    checkCount("simul_pulses", cnt_hH + cnt_hL + cnt_mH + cnt_mL, 0);

    $display("[TB] blink and inactivity timeout in SET_MH");
    pressMode();
    pressMode();
    pressMode();
    applyStimulus(1'b1, 1'b0, 8);
    entry = last_sd_change;
    clearMonitor();
    elapsed = -1;
    for (int k = 0; k < 150 && elapsed < 0; k++) begin
      applyStimulus(1'b0, 1'b0, 1);
      if (bus.run_en === 1'b1) elapsed = cyc - entry;
    end
    checkCount("timeout_cycles", elapsed, 100);
    checkCount("blink_toggles", blink_toggles, 12);
    checkCount("timeout_sec_clr", sec_cnt, 1);
    checkCount("timeout_blink", int'(bus.blink_on), 1);

    $display("[TB] reset during auto-repeat in SET_ML");
    for (int k = 0; k < 4; k++) pressMode();
    applyStimulus(1'b0, 1'b1, 35);
    #2 clr = 1'b1;
    #1 checkOutput("clr_async", obs_vec(), RESET_VEC);
    model_reset();
    applyStimulus(1'b0, 1'b1, 3);
    clr = 1'b0;
    clearMonitor();
    applyStimulus(1'b0, 1'b1, 20);
    checkCount("clr_no_pulse", cnt_hH + cnt_hL + cnt_mH + cnt_mL, 0);
    checkCount("clr_run_en", int'(bus.run_en), 1);
    applyStimulus(1'b0, 1'b0, 10);

    $display("[TB] random button activity");
    for (int s = 0; s < 150; s++) begin
      logic rm, ri;
      rm = ($urandom_range(0, 3) == 0);
      ri = ($urandom_range(0, 2) == 0);
      applyStimulus(rm, ri, $urandom_range(1, 14));
    end
    applyStimulus(1'b0, 1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
